// File: rtl/fifo_thresh_pkg.sv
// -----------------------------------------------------------------------------
// fifo_thresh_pkg
// Shared definitions for the thresholded FIFO slice:
//   - default data/address widths used by fifo_thresh and fifo_mem
//   - fifo_depth(): depth derived from the address width
//   - fifo_status_t and calc_status(): the level flags derived from a count
//   - next_sticky(): update rule for the sticky error flags
// -----------------------------------------------------------------------------
package fifo_thresh_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Level flags that are all derived from the same word count.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic fifo_status_t calc_status(input int cnt,
                                               input int depth,
                                               input int af_level,
                                               input int ae_level);
    fifo_status_t s;
    s.empty        = (cnt == 0);
    s.full         = (cnt == depth);
    s.almost_empty = (cnt <= ae_level);
    s.almost_full  = (cnt >= af_level);
    return s;
  endfunction

  // A new error in the same cycle as a clear leaves the flag set.
  function automatic logic next_sticky(input logic flag,
                                       input logic clr,
                                       input logic new_err);
    return (flag & ~clr) | new_err;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port register array for the FIFO: synchronous write,
// asynchronous read. Contents are intentionally not reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_thresh_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh.sv
// -----------------------------------------------------------------------------
// fifo_thresh
// Single-clock FIFO with selectable read mode (first-word-fall-through or
// registered read), programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags with a synchronous clear.
// Ports:
//   clk           in   rising-edge clock
//   res           in   asynchronous active-low reset
//   push          in   write request
//   pull          in   read request
//   din           in   write data, taken when push is accepted
//   clr_err       in   synchronous clear of overflow/underflow
//   dout          out  read data (FWFT: head word; else registered read)
//   count         out  stored words, 0..DEPTH
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AE_LEVEL
//   almost_full   out  count >= AF_LEVEL
//   overflow      out  sticky: a push was rejected
//   underflow     out  sticky: a pull was rejected
// -----------------------------------------------------------------------------
module fifo_thresh
  import fifo_thresh_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit FWFT       = 1'b1,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  push,
  input  logic                  pull,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam fifo_status_t RST_STATUS = calc_status(0, DEPTH, AF_LEVEL, AE_LEVEL);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

  // Illegal thresholds stop elaboration rather than silently misbehaving.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_thresh: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_thresh: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  fifo_status_t          status_q;
  fifo_status_t          status_next;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  push_ok;
  logic                  pull_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // A pull frees a slot in the same edge, so a full FIFO can still take a
  // push when it is paired with a successful pull.
  assign pull_ok = pull & ~status_q.empty;
  assign push_ok = push & (~status_q.full | pull_ok);

  assign count_next = count_q
                    + {{ADDR_WIDTH{1'b0}}, push_ok}
                    - {{ADDR_WIDTH{1'b0}}, pull_ok};

  // Flags are computed from the next count and registered, so they move in
  // the same cycle as count and never combinationally from push/pull.
  assign status_next = calc_status(int'(count_next), DEPTH, AF_LEVEL, AE_LEVEL);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pull_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_next;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      status_q <= RST_STATUS;
    end else begin
      status_q <= status_next;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= next_sticky(overflow_q,  clr_err, push & ~push_ok);
      underflow_q <= next_sticky(underflow_q, clr_err, pull & ~pull_ok);
    end
  end

  if (FWFT) begin : g_fwft
    // The head word is shown directly; while empty the array slot is stale
    // or uninitialised, so it is masked to zero to keep dout deterministic.
    assign dout = status_q.empty ? '0 : mem_rdata;
  end else begin : g_regread
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        dout_q <= '0;
      end else if (pull_ok) begin
        dout_q <= mem_rdata;
      end
    end

    assign dout = dout_q;
  end

  assign count        = count_q;
  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// -----------------------------------------------------------------------------
// tb_fifo_thresh
// Self-checking bench for fifo_thresh. Two instances share all inputs:
// u_fwft (FWFT=1) and u_reg (FWFT=0), DATA_WIDTH=8, ADDR_WIDTH=3,
// AF_LEVEL=6, AE_LEVEL=1.
// -----------------------------------------------------------------------------
module tb_fifo_thresh;

  logic       clk;
  logic       res;
  logic       push;
  logic       pull;
  logic [7:0] din;
  logic       clr_err;

  logic [7:0] dout;
  logic [3:0] count;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  logic [7:0] dout_r;
  logic [3:0] count_r;
  logic       empty_r, full_r, ae_r, af_r, ovf_r, unf_r;

  int n_compared;
  int n_mismatched;

  fifo_thresh #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .FWFT       (1'b1),
    .AF_LEVEL   (6),
    .AE_LEVEL   (1)
  ) u_fwft (
    .clk          (clk),
    .res          (res),
    .push         (push),
    .pull         (pull),
    .din          (din),
    .clr_err      (clr_err),
    .dout         (dout),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  fifo_thresh #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .FWFT       (1'b0),
    .AF_LEVEL   (6),
    .AE_LEVEL   (1)
  ) u_reg (
    .clk          (clk),
    .res          (res),
    .push         (push),
    .pull         (pull),
    .din          (din),
    .clr_err      (clr_err),
    .dout         (dout_r),
    .count        (count_r),
    .empty        (empty_r),
    .full         (full_r),
    .almost_empty (ae_r),
    .almost_full  (af_r),
    .overflow     (ovf_r),
    .underflow    (unf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // flags field order: {empty, full, almost_empty, almost_full, overflow, underflow}
  typedef struct {
    logic       push;
    logic       pull;
    logic       clr;
    logic [7:0] din;
    int         exp_count;
    logic [5:0] exp_flags;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic [7:0] exp_dout_r;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic p, input logic q, input logic c,
                              input logic [7:0] d, input int cnt,
                              input logic [5:0] fl, input logic chk,
                              input logic [7:0] dv, input logic [7:0] dr);
    vec_t v;
    v.push = p; v.pull = q; v.clr = c; v.din = d;
    v.exp_count = cnt; v.exp_flags = fl; v.chk_dout = chk;
    v.exp_dout = dv; v.exp_dout_r = dr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q,
                               input logic [7:0] d, input logic c);
    @(negedge clk);
    push = p; pull = q; din = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pull = 1'b0; clr_err = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input int cnt, input logic [5:0] fl);
    checkOutput({tag, " count"},        32'(count),        32'(cnt));
    checkOutput({tag, " empty"},        32'(empty),        32'(fl[5]));
    checkOutput({tag, " full"},         32'(full),         32'(fl[4]));
    checkOutput({tag, " almost_empty"}, 32'(almost_empty), 32'(fl[3]));
    checkOutput({tag, " almost_full"},  32'(almost_full),  32'(fl[2]));
    checkOutput({tag, " overflow"},     32'(overflow),     32'(fl[1]));
    checkOutput({tag, " underflow"},    32'(underflow),    32'(fl[0]));
    checkOutput({tag, " reg count"},    32'(count_r),      32'(cnt));
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    res     = 1'b0;
    push    = 1'b0;
    pull    = 1'b0;
    din     = 8'h00;
    clr_err = 1'b0;

    // Fill 0..7, overflow push, drain, then underflow and clear handling.
    vecs[0]  = mk(1,0,0,8'h00,1,6'b001000,1,8'h00,8'h00);
    vecs[1]  = mk(1,0,0,8'h01,2,6'b000000,1,8'h00,8'h00);
    vecs[2]  = mk(1,0,0,8'h02,3,6'b000000,1,8'h00,8'h00);
    vecs[3]  = mk(1,0,0,8'h03,4,6'b000000,1,8'h00,8'h00);
    vecs[4]  = mk(1,0,0,8'h04,5,6'b000000,1,8'h00,8'h00);
    vecs[5]  = mk(1,0,0,8'h05,6,6'b000100,1,8'h00,8'h00);
    vecs[6]  = mk(1,0,0,8'h06,7,6'b000100,1,8'h00,8'h00);
    vecs[7]  = mk(1,0,0,8'h07,8,6'b010100,1,8'h00,8'h00);
    vecs[8]  = mk(1,0,0,8'hEE,8,6'b010110,1,8'h00,8'h00);
    vecs[9]  = mk(0,1,0,8'h00,7,6'b000110,1,8'h01,8'h00);
    vecs[10] = mk(0,1,0,8'h00,6,6'b000110,1,8'h02,8'h01);
    vecs[11] = mk(0,1,0,8'h00,5,6'b000010,1,8'h03,8'h02);
    vecs[12] = mk(0,1,0,8'h00,4,6'b000010,1,8'h04,8'h03);
    vecs[13] = mk(0,1,0,8'h00,3,6'b000010,1,8'h05,8'h04);
    vecs[14] = mk(0,1,0,8'h00,2,6'b000010,1,8'h06,8'h05);
    vecs[15] = mk(0,1,0,8'h00,1,6'b001010,1,8'h07,8'h06);
    vecs[16] = mk(0,1,0,8'h00,0,6'b101010,0,8'h00,8'h07);
    vecs[17] = mk(0,1,0,8'h00,0,6'b101011,0,8'h00,8'h07);
    vecs[18] = mk(0,0,1,8'h00,0,6'b101000,0,8'h00,8'h07);
    vecs[19] = mk(0,1,1,8'h00,0,6'b101001,0,8'h00,8'h07);
    vecs[20] = mk(0,0,1,8'h00,0,6'b101000,0,8'h00,8'h07);

    // Reset held for one clock, then released.
    @(posedge clk);
    #1;
    checkFlags("reset held", 0, 6'b101000);
    @(negedge clk);
    res = 1'b1;
    #1;
    checkFlags("reset released", 0, 6'b101000);
    checkOutput("reset dout",     32'(dout),   32'h0);
    checkOutput("reset dout_reg", 32'(dout_r), 32'h0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].push, vecs[i].pull, vecs[i].din, vecs[i].clr);
      checkFlags($sformatf("v%0d", i), vecs[i].exp_count, vecs[i].exp_flags);
      if (vecs[i].chk_dout) begin
        checkOutput($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      end
      checkOutput($sformatf("v%0d dout_reg", i), 32'(dout_r), 32'(vecs[i].exp_dout_r));
    end

    // Full FIFO with simultaneous push and pull: both accepted, no overflow.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    end
    checkFlags("fill2", 8, 6'b010100);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    checkFlags("full push+pull", 8, 6'b010100);
    checkOutput("full push+pull dout",     32'(dout),   32'h11);
    checkOutput("full push+pull dout_reg", 32'(dout_r), 32'h10);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want;
      want = (i == 7) ? 8'hA5 : 8'(8'h11 + i);
      checkOutput($sformatf("drain%0d dout", i), 32'(dout), 32'(want));
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("drain%0d dout_reg", i), 32'(dout_r), 32'(want));
    end
    checkFlags("drained", 0, 6'b101000);

    // Wrap-around: count held at 3 across 12 push+pull cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    end
    checkFlags("wrap prime", 3, 6'b000000);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("wrap%0d dout", k), 32'(dout), 32'(8'h30 + k));
      applyStimulus(1'b1, 1'b1, 8'(8'h33 + k), 1'b0);
      checkOutput($sformatf("wrap%0d count", k), 32'(count), 32'd3);
      checkOutput($sformatf("wrap%0d dout_reg", k), 32'(dout_r), 32'(8'h30 + k));
    end
    checkOutput("wrap final dout", 32'(dout), 32'h3C);

    // Asynchronous reset in the middle of a burst at count 5.
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h41, 1'b0);
    checkFlags("pre-reset", 5, 6'b000000);
    @(negedge clk);
    #1;
    res = 1'b0;
    #1;
    checkFlags("async reset", 0, 6'b101000);
    checkOutput("async reset dout",     32'(dout),   32'h0);
    checkOutput("async reset dout_reg", 32'(dout_r), 32'h0);
    @(negedge clk);
    res = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
    checkFlags("post-reset push", 1, 6'b001000);
    checkOutput("post-reset dout", 32'(dout), 32'h5A);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkFlags("post-reset pull", 0, 6'b101000);
    checkOutput("post-reset dout_reg", 32'(dout_r), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
